// File: rtl/parking_gate_arbiter_if.sv
// parking_gate_arbiter_if
// Bundles the lane-side handshake and barrier/status signals of the shared
// car-park barrier arbiter.
//   master : the lane controllers and barrier sensor (drive the requests and
//            car_passed, observe the grants and the status)
//   slave  : the arbiter itself
// Signals:
//   ent_req[1:0]   per-entry-lane request level
//   exit_req       exit-lane request level
//   car_passed     one-cycle pulse from the pass-through sensor
//   ent_grant[1:0] one-hot, one-cycle entry grant pulse
//   exit_grant     one-cycle exit grant pulse
//   gate_open      barrier actuator command
//   gate_dir       0 = entry, 1 = exit, valid while gate_open
//   occupancy      cars currently parked
//   lot_full       occupancy at capacity
//   lot_empty      occupancy zero
//   timeout_err    one-cycle pulse when a grant expires without a pass
interface parking_gate_arbiter_if #(
    parameter int CW = 4
);
    logic [1:0]    ent_req;
    logic          exit_req;
    logic          car_passed;
    logic [1:0]    ent_grant;
    logic          exit_grant;
    logic          gate_open;
    logic          gate_dir;
    logic [CW-1:0] occupancy;
    logic          lot_full;
    logic          lot_empty;
    logic          timeout_err;

    modport master (
        output ent_req, exit_req, car_passed,
        input  ent_grant, exit_grant, gate_open, gate_dir,
        input  occupancy, lot_full, lot_empty, timeout_err
    );

    modport slave (
        input  ent_req, exit_req, car_passed,
        output ent_grant, exit_grant, gate_open, gate_dir,
        output occupancy, lot_full, lot_empty, timeout_err
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
// Arbitrates two entry lanes and one exit lane onto a single barrier,
// holds the barrier open until the car clears or the open timer expires,
// and keeps the lot occupancy count with full/empty status.
// Parameters:
//   CAPACITY    number of parking slots (1 .. 2**CW-1)
//   OPEN_CYCLES maximum open cycles per grant (>= 2)
//   CW          occupancy counter width
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset
//   bus    slave side of parking_gate_arbiter_if (requests, grants,
//          barrier command and lot status)
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int OPEN_CYCLES = 16,
    parameter int CW          = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_gate_arbiter_if.slave  bus
);

    localparam int              TW         = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0]   CAP        = CW'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] occupancy;
    logic          last_served;
    logic [1:0]    ent_grant;
    logic          exit_grant;
    logic          gate_open;
    logic          gate_dir;
    logic          timeout_err;

    logic          full;
    logic          empty;
    logic          pick_exit;
    logic [1:0]    pick_ent;

    // Status flags come straight off the occupancy register so the lane
    // displays see them in the same cycle the count changes.
    assign full  = (occupancy == CAP);
    assign empty = (occupancy == '0);

    // Arbitration decision for the IDLE cycle. Exit wins whenever a car is
    // inside, since it frees a slot. Entries only go when there is room; on
    // a tie the lane that was not served last gets the barrier. Requests that
    // cannot be served simply stay pending upstream.
    always_comb begin
        pick_exit = 1'b0;
        pick_ent  = 2'b00;
        if (bus.exit_req && !empty) begin
            pick_exit = 1'b1;
        end else if (!full) begin
            case (bus.ent_req)
                2'b01:   pick_ent = 2'b01;
                2'b10:   pick_ent = 2'b10;
                2'b11:   pick_ent = last_served ? 2'b01 : 2'b10;
                default: pick_ent = 2'b00;
            endcase
        end
    end

    // Barrier sequencing: IDLE grants, OPEN waits for the pass or the timer,
    // CLOSING gives the barrier one low cycle before the next grant. All
    // outputs are registered here; grant and timeout pulses default low so
    // they last exactly one cycle. The occupancy update is applied on the
    // edge that leaves OPEN so it is visible in the CLOSING cycle, and an
    // interrupted grant never touches the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            occupancy   <= '0;
            last_served <= 1'b1;
            ent_grant   <= 2'b00;
            exit_grant  <= 1'b0;
            gate_open   <= 1'b0;
            gate_dir    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ent_grant   <= 2'b00;
            exit_grant  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_exit) begin
                        state      <= OPEN;
                        exit_grant <= 1'b1;
                        gate_open  <= 1'b1;
                        gate_dir   <= 1'b1;
                        timer      <= '0;
                    end else if (pick_ent != 2'b00) begin
                        state       <= OPEN;
                        ent_grant   <= pick_ent;
                        gate_open   <= 1'b1;
                        gate_dir    <= 1'b0;
                        timer       <= '0;
                        last_served <= pick_ent[1];
                    end
                end
                OPEN: begin
                    // A pass on the final timer cycle still counts and
                    // suppresses the timeout.
                    if (bus.car_passed) begin
                        state     <= CLOSING;
                        gate_open <= 1'b0;
                        if (gate_dir) begin
                            occupancy <= occupancy - CW'(1);
                        end else begin
                            occupancy <= occupancy + CW'(1);
                        end
                    end else if (timer == TIMER_LAST) begin
                        state       <= CLOSING;
                        gate_open   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CLOSING: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ent_grant   = ent_grant;
    assign bus.exit_grant  = exit_grant;
    assign bus.gate_open   = gate_open;
    assign bus.gate_dir    = gate_dir;
    assign bus.occupancy   = occupancy;
    assign bus.lot_full    = full;
    assign bus.lot_empty   = empty;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter
// Self-checking bench for parking_gate_arbiter. A timestamp-based model of
// the barrier (when did the current opening start, when may the arbiter
// look at requests again, how many cars are inside) predicts every output
// each cycle; directed scenarios add literal expectations on top.
module tb_parking_gate_arbiter;

    localparam int CAPACITY    = 8;
    localparam int OPEN_CYCLES = 16;
    localparam int CW          = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    parking_gate_arbiter_if #(.CW(CW)) bus();

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .OPEN_CYCLES (OPEN_CYCLES),
        .CW          (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Shared comparison helper; automatic because the model checker and the
    // directed scenarios may call it in the same time step.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives all lane-side inputs at once.
    task automatic applyStimulus(input logic rst, input logic [1:0] ent,
                                 input logic ex, input logic cp);
        reset          = rst;
        bus.ent_req    = ent;
        bus.exit_req   = ex;
        bus.car_passed = cp;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Periods are numbered by rising edges; at each edge
    // the inputs of the period that just ended decide the outputs of the
    // next one. The barrier is described by when the current opening began
    // and from which period the arbiter is free again.
    // ------------------------------------------------------------------
    int         period     = 0;
    int         openStart  = -1;
    int         idleFrom   = 0;
    int         mOcc       = 0;
    int         mLast      = 1;
    int         mLane      = 0;
    logic       modelValid = 1'b0;
    logic       mDir       = 1'b0;
    logic       mOpen      = 1'b0;
    logic       mTimeout   = 1'b0;
    logic       mExitGrant = 1'b0;
    logic [1:0] mEntGrant  = 2'b00;
    logic [1:0] mReq;

    always @(posedge clk) begin
        mEntGrant  = 2'b00;
        mExitGrant = 1'b0;
        mTimeout   = 1'b0;
        mReq       = bus.ent_req;
        if (reset) begin
            modelValid = 1'b1;
            mOcc       = 0;
            mLast      = 1;
            mDir       = 1'b0;
            mOpen      = 1'b0;
            openStart  = -1;
            idleFrom   = period + 1;
        end else if (modelValid) begin
            if (openStart >= 0) begin
                if (bus.car_passed) begin
                    mOcc      = mDir ? mOcc - 1 : mOcc + 1;
                    openStart = -1;
                    mOpen     = 1'b0;
                    idleFrom  = period + 2;
                end else if (period - openStart == OPEN_CYCLES - 1) begin
                    mTimeout  = 1'b1;
                    openStart = -1;
                    mOpen     = 1'b0;
                    idleFrom  = period + 2;
                end
            end else if (period >= idleFrom) begin
                if (bus.exit_req && mOcc > 0) begin
                    mExitGrant = 1'b1;
                    mDir       = 1'b1;
                    mOpen      = 1'b1;
                    openStart  = period + 1;
                end else if (mOcc < CAPACITY && mReq != 2'b00) begin
                    mLane      = (mReq == 2'b11) ? 1 - mLast : (mReq[1] ? 1 : 0);
                    mEntGrant  = 2'(1 << mLane);
                    mLast      = mLane;
                    mDir       = 1'b0;
                    mOpen      = 1'b1;
                    openStart  = period + 1;
                end
            end
        end
        period = period + 1;
    end

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_ent_grant", 32'(bus.ent_grant), 32'(mEntGrant));
            checkOutput("model_exit_grant", 32'(bus.exit_grant), 32'(mExitGrant));
            checkOutput("model_gate_open", 32'(bus.gate_open), 32'(mOpen));
            checkOutput("model_occupancy", 32'(bus.occupancy), 32'(mOcc));
            checkOutput("model_lot_full", 32'(bus.lot_full), 32'(mOcc == CAPACITY));
            checkOutput("model_lot_empty", 32'(bus.lot_empty), 32'(mOcc == 0));
            checkOutput("model_timeout", 32'(bus.timeout_err), 32'(mTimeout));
            if (mOpen) begin
                checkOutput("model_gate_dir", 32'(bus.gate_dir), 32'(mDir));
            end
        end
    end

    // Waits a bounded number of cycles for any grant pulse.
    task automatic waitGrant(input int limit, output logic [1:0] gEnt,
                             output logic gEx, output logic seen);
        gEnt = 2'b00;
        gEx  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            nextCycle();
            if (bus.ent_grant != 2'b00 || bus.exit_grant) begin
                gEnt = bus.ent_grant;
                gEx  = bus.exit_grant;
                seen = 1'b1;
                return;
            end
        end
    endtask

    // Raises requests, expects a specific grant, drops the served request
    // and optionally pulses car_passed the cycle after the grant. Returns in
    // the CLOSING cycle of that grant.
    task automatic serveCar(input string name, input logic [1:0] ent, input logic ex,
                            input logic [1:0] expEnt, input logic expEx, input logic pass);
        logic [1:0] gEnt;
        logic       gEx;
        logic       seen;
        bus.ent_req  = ent;
        bus.exit_req = ex;
        waitGrant(30, gEnt, gEx, seen);
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_ent"}, 32'(gEnt), 32'(expEnt));
        checkOutput({name, "_exit"}, 32'(gEx), 32'(expEx));
        checkOutput({name, "_dir"}, 32'(bus.gate_dir), 32'(expEx));
        bus.ent_req = bus.ent_req & ~gEnt;
        if (gEx) begin
            bus.exit_req = 1'b0;
        end
        if (pass) begin
            nextCycle();
            bus.car_passed = 1'b1;
            nextCycle();
            bus.car_passed = 1'b0;
        end
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [1:0] gEnt;
        logic       gEx;
        logic       seen;
        int         openCount;
        int         grantCount;

        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (3) nextCycle();
        checkOutput("rst_gate_open", 32'(bus.gate_open), 32'd0);
        checkOutput("rst_gate_dir", 32'(bus.gate_dir), 32'd0);
        checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);
        checkOutput("rst_lot_empty", 32'(bus.lot_empty), 32'd1);
        checkOutput("rst_lot_full", 32'(bus.lot_full), 32'd0);
        checkOutput("rst_grants", 32'({bus.ent_grant, bus.exit_grant}), 32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout_err), 32'd0);

        // Single entry: grant one cycle after the request, count after pass.
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        nextCycle();
        bus.ent_req = 2'b01;
        nextCycle();
        checkOutput("t1_ent_grant", 32'(bus.ent_grant), 32'h1);
        checkOutput("t1_gate_open", 32'(bus.gate_open), 32'd1);
        bus.ent_req = 2'b00;
        nextCycle();
        nextCycle();
        bus.car_passed = 1'b1;
        nextCycle();
        bus.car_passed = 1'b0;
        checkOutput("t1_occupancy", 32'(bus.occupancy), 32'd1);
        checkOutput("t1_gate_closed", 32'(bus.gate_open), 32'd0);

        // Round-robin from a fresh reset: lane 0 wins the first tie.
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        serveCar("rr0", 2'b11, 1'b0, 2'b01, 1'b0, 1'b1);
        serveCar("rr1", 2'b11, 1'b0, 2'b10, 1'b0, 1'b1);
        serveCar("rr2", 2'b11, 1'b0, 2'b01, 1'b0, 1'b1);
        serveCar("rr3", 2'b11, 1'b0, 2'b10, 1'b0, 1'b1);
        checkOutput("rr_occupancy", 32'(bus.occupancy), 32'd4);

        // Exit priority with occupancy 3 and both entries requesting.
        serveCar("exit_alone", 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
        checkOutput("exit_alone_occ", 32'(bus.occupancy), 32'd3);
        serveCar("exit_prio", 2'b11, 1'b1, 2'b00, 1'b1, 1'b1);
        checkOutput("exit_prio_occ", 32'(bus.occupancy), 32'd2);
        serveCar("entry_after_exit", 2'b11, 1'b0, 2'b01, 1'b0, 1'b1);
        checkOutput("entry_after_exit_occ", 32'(bus.occupancy), 32'd3);

        // Fill to capacity, then entries must be held off.
        for (int i = 0; i < 5; i++) begin
            serveCar("fill", 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);
        end
        nextCycle();
        checkOutput("full_occupancy", 32'(bus.occupancy), 32'd8);
        checkOutput("full_flag", 32'(bus.lot_full), 32'd1);
        bus.ent_req = 2'b01;
        grantCount = 0;
        for (int i = 0; i < 50; i++) begin
            nextCycle();
            if (bus.ent_grant != 2'b00) grantCount++;
        end
        checkOutput("full_blocks_entry", 32'(grantCount), 32'd0);
        serveCar("exit_when_full", 2'b01, 1'b1, 2'b00, 1'b1, 1'b1);
        checkOutput("exit_when_full_occ", 32'(bus.occupancy), 32'd7);
        serveCar("pending_entry", 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);
        checkOutput("pending_entry_occ", 32'(bus.occupancy), 32'd8);

        // Timeout: barrier open for exactly OPEN_CYCLES cycles.
        bus.exit_req = 1'b1;
        waitGrant(30, gEnt, gEx, seen);
        checkOutput("to_grant", 32'(gEx), 32'd1);
        bus.exit_req = 1'b0;
        openCount = 1;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (!bus.gate_open) break;
            openCount++;
        end
        checkOutput("to_open_len", 32'(openCount), 32'd16);
        checkOutput("to_pulse", 32'(bus.timeout_err), 32'd1);
        nextCycle();
        checkOutput("to_one_cycle", 32'(bus.timeout_err), 32'd0);
        checkOutput("to_occ_kept", 32'(bus.occupancy), 32'd8);

        // Pass on the final open cycle counts and suppresses the timeout.
        bus.exit_req = 1'b1;
        waitGrant(30, gEnt, gEx, seen);
        checkOutput("late_grant", 32'(gEx), 32'd1);
        bus.exit_req = 1'b0;
        repeat (14) nextCycle();
        nextCycle();
        checkOutput("late_still_open", 32'(bus.gate_open), 32'd1);
        bus.car_passed = 1'b1;
        nextCycle();
        bus.car_passed = 1'b0;
        checkOutput("late_closed", 32'(bus.gate_open), 32'd0);
        checkOutput("late_no_timeout", 32'(bus.timeout_err), 32'd0);
        checkOutput("late_occ", 32'(bus.occupancy), 32'd7);

        // Reset in the middle of an opening with five cars inside.
        serveCar("exit_a", 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
        serveCar("exit_b", 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
        checkOutput("pre_reset_occ", 32'(bus.occupancy), 32'd5);
        serveCar("mid_open", 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("mid_rst_gate", 32'(bus.gate_open), 32'd0);
        checkOutput("mid_rst_occ", 32'(bus.occupancy), 32'd0);
        checkOutput("mid_rst_empty", 32'(bus.lot_empty), 32'd1);
        checkOutput("mid_rst_dir", 32'(bus.gate_dir), 32'd0);
        bus.exit_req = 1'b1;
        grantCount = 0;
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            if (bus.exit_grant) grantCount++;
        end
        checkOutput("empty_blocks_exit", 32'(grantCount), 32'd0);

        // The pending exit must not block an entry, and the tie pointer is
        // back at its reset value.
        serveCar("post_rst_tie", 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        bus.exit_req = 1'b0;
        nextCycle();
        checkOutput("post_rst_occ", 32'(bus.occupancy), 32'd1);

        repeat (3) nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shared-barrier controller for the car park: arbitrates two entry lanes and one exit lane onto a single barrier actuator and tracks lot occupancy against a fixed capacity. It sits downstream of the per-lane password/entry controllers, which raise a request once a driver is authorised. It also sits upstream of the barrier actuator and pass-through sensor. The block grants one lane at a time, holds the barrier open until the car clears or a timeout expires, and exports full/empty status for the lane displays.

## Interface
- CAPACITY, 8: number of parking slots; range 1 to 2^CW-1.
- OPEN_CYCLES, 16: maximum cycles the barrier stays open per grant; must be at least 2.
- CW, 4: occupancy counter width.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- ent_req  input  2  per-entry-lane request; level, held until that lane's grant.
- exit_req  input  1  exit-lane request; level, held until exit_grant.
- car_passed  input  1  one-cycle pulse from the barrier sensor when a vehicle clears.
- ent_grant  output  2  one-hot, one-cycle grant pulse to the served entry lane.
- exit_grant  output  1  one-cycle grant pulse to the exit lane.
- gate_open  output  1  barrier actuator command.
- gate_dir  output  1  0 = entry, 1 = exit; valid while gate_open = 1.
- occupancy  output  CW  cars currently in the lot.
- lot_full  output  1  occupancy == CAPACITY.
- lot_empty  output  1  occupancy == 0.
- timeout_err  output  1  one-cycle pulse when a grant expires without car_passed.

## Operation
- States:
  - IDLE: gate closed; requests evaluated here.
  - OPEN: gate_open = 1; open timer runs.
  - CLOSING: gate_open = 0 for one cycle; occupancy update lands here.
- Arbitration in IDLE, in priority order:
  - exit_req is served first when lot_empty = 0, because an exit frees a slot.
  - Otherwise an entry request is served only when lot_full = 0.
  - If one entry lane requests, it is served.
  - If both entry lanes request, round-robin applies: serve the lane not served last. The last_served pointer resets to lane 1, so lane 0 wins the first tie.
  - last_served is updated only on an entry grant.
  - exit_req while lot_empty = 1 is never granted and stays pending.
  - ent_req while lot_full = 1 is never granted and stays pending.
- IDLE -> OPEN on any grantable request. In the first OPEN cycle:
  - the matching grant pulse is asserted;
  - gate_dir is latched for the whole OPEN interval;
  - the timer is 0.
- In OPEN, car_passed = 1 -> CLOSING:
  - occupancy increments for an entry grant, decrements for an exit grant;
  - the count never wraps, because grants are gated by full/empty.
- In OPEN with timer == OPEN_CYCLES-1 and car_passed = 0 -> CLOSING, with timeout_err = 1 for one cycle and occupancy unchanged.
- car_passed and timer expiry in the same cycle: the pass counts and no timeout_err is raised.
- car_passed outside OPEN is ignored.
- CLOSING -> IDLE unconditionally.
- lot_full and lot_empty are decoded combinationally from the occupancy register.
- Reset (asserted at any time, including mid-OPEN) gives:
  - state IDLE, occupancy 0, gate_open 0, gate_dir 0;
  - all grants 0, timeout_err 0, last_served = lane 1;
  - lot_empty 1, lot_full 0;
  - no occupancy change for an interrupted grant.

## Timing
- Request sampled in IDLE at cycle N -> grant pulse and gate_open = 1 at N+1, so grant latency is 1 cycle.
- OPEN entered at T, car_passed at T+k -> gate_open = 0 and updated occupancy at T+k+1, IDLE at T+k+2, next grant at T+k+3 at the earliest.
- No pass seen -> gate_open is high for exactly OPEN_CYCLES cycles (T to T+OPEN_CYCLES-1); timeout_err and gate_open = 0 at T+OPEN_CYCLES.
- Minimum spacing between grants is 3 cycles; gate_open always has at least one low cycle between grants.
- All outputs are registered except lot_full and lot_empty.

## Test plan
- Reset, then ent_req = 01 at cycle 2 -> ent_grant = 01 and gate_open = 1 at cycle 3; car_passed at cycle 5 -> occupancy = 1 and gate_open = 0 at cycle 6.
- Both entry lanes held requesting, each grant followed by car_passed one cycle later -> grants alternate lane 0, lane 1, lane 0, lane 1; occupancy reaches 4.
- exit_req and ent_req = 11 in the same IDLE cycle with occupancy = 3 -> exit_grant first, gate_dir = 1; occupancy 2 after the pass; entry is served next.
- Fill to CAPACITY = 8 -> lot_full = 1; further ent_req gets no grant for 50 cycles; one exit pass -> occupancy 7 and the pending entry is granted.
- Grant with no car_passed -> gate_open high for exactly 16 cycles, one timeout_err pulse, occupancy unchanged; car_passed on the 16th open cycle -> counted, no timeout_err.
- reset asserted in the middle of OPEN with occupancy 5 -> the next cycle shows IDLE, occupancy 0, gate_open 0, lot_empty 1; exit_req afterwards is not granted.
